// File: rtl/fazyrv_ccx_alu.sv
// fazyrv_ccx_alu
// Chunk-serial custom-instruction execution unit for the fazyrv core.
// Operands arrive one chunk per cycle, LSB chunk first, starting in the cycle
// of ccx_req_i. After the last chunk the 32-bit result of the selected op is
// registered, held for RES_DLY cycles, then streamed out LSB chunk first.
// ccx_resp_o marks the final result chunk. A request that arrives while the
// unit is busy is dropped and sets the sticky err_o flag.

module fazyrv_ccx_alu #(
    parameter int CHUNKSIZE = 2,
    parameter int RES_DLY   = 1,
    parameter int SELW      = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic [SELW-1:0]      ccx_sel_i,
    input  logic                 ccx_req_i,
    input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
    input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
    output logic [CHUNKSIZE-1:0] ccx_res_o,
    output logic                 ccx_resp_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int NCHUNK = 32 / CHUNKSIZE;
    localparam int CNTW   = $clog2(NCHUNK);

    localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(NCHUNK - 1);

    // WAIT holds for exactly RES_DLY cycles: the counter is loaded with
    // RES_DLY-1 and the unit leaves WAIT in the cycle it reads zero.
    localparam logic [3:0] DLY_LOAD = (RES_DLY > 0) ? 4'(RES_DLY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WAIT    = 2'd2,
        EMIT    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_XOR  = 2'd1,
        OP_ADD  = 2'd2,
        OP_MINU = 2'd3
    } op_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic [3:0]      dly_q,   dly_d;
    logic [1:0]      op_q,    op_d;
    logic [31:0]     a_q,     a_d;
    logic [31:0]     b_q,     b_d;
    logic [31:0]     res_q,   res_d;
    logic            err_q,   err_d;

    logic [1:0]      sel_lo;
    logic [31:0]     a_full;
    logic [31:0]     b_full;
    logic [31:0]     alu_res;

    // Only the two low select bits pick the op; any wider select bits are
    // ignored, and a one-bit select reaches only AND/XOR.
    generate
        if (SELW >= 2) begin : g_sel_wide
            assign sel_lo = ccx_sel_i[1:0];
        end else begin : g_sel_narrow
            assign sel_lo = {1'b0, ccx_sel_i[0]};
        end
    endgenerate

    // The last operand chunk is still on the inputs when the result is
    // registered, so splice it above the chunks already collected.
    assign a_full = {ccx_rs_a_i, a_q[31-CHUNKSIZE:0]};
    assign b_full = {ccx_rs_b_i, b_q[31-CHUNKSIZE:0]};

    // The four ops on the fully assembled operands; the add carry is dropped.
    always_comb begin
        alu_res = '0;
        case (op_t'(op_q))
            OP_AND:  alu_res = a_full & b_full;
            OP_XOR:  alu_res = a_full ^ b_full;
            OP_ADD:  alu_res = a_full + b_full;
            OP_MINU: alu_res = (a_full < b_full) ? a_full : b_full;
            default: alu_res = '0;
        endcase
    end

    // Sequencing: collect chunks, compute, optional delay, emit chunks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q | (ccx_req_i && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (ccx_req_i) begin
                    op_d    = sel_lo;
                    a_d     = 32'(ccx_rs_a_i);
                    b_d     = 32'(ccx_rs_b_i);
                    cnt_d   = CNTW'(1);
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CNTW'(k)) begin
                        a_d[k*CHUNKSIZE +: CHUNKSIZE] = ccx_rs_a_i;
                        b_d[k*CHUNKSIZE +: CHUNKSIZE] = ccx_rs_b_i;
                    end
                end
                if (cnt_q == LAST_CHUNK) begin
                    res_d   = alu_res;
                    cnt_d   = '0;
                    dly_d   = DLY_LOAD;
                    state_d = (RES_DLY > 0) ? WAIT : EMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT: begin
                if (dly_q == 4'd0) begin
                    state_d = EMIT;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end

            EMIT: begin
                res_d = res_q >> CHUNKSIZE;
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        ccx_res_o  = (state_q == EMIT) ? res_q[CHUNKSIZE-1:0] : '0;
        ccx_resp_o = (state_q == EMIT) && (cnt_q == LAST_CHUNK);
        busy_o     = (state_q != IDLE);
        err_o      = err_q;
    end

endmodule

// File: tb/tb_fazyrv_ccx_alu.sv
// Bench for fazyrv_ccx_alu: five instances with different chunk sizes and
// result delays run the same directed operations side by side. Expected
// results and their timing go into a scoreboard queue per instance when a
// request is driven; a monitor pops and compares them as the chunks stream out.

module tb_fazyrv_ccx_alu;

    localparam int NINST = 5;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  sel;
    logic [4:0]  reqV;
    logic [7:0]  aIn [NINST];
    logic [7:0]  bIn [NINST];

    wire  [1:0]  res0;
    wire  [0:0]  res1;
    wire  [3:0]  res2;
    wire  [7:0]  res3;
    wire  [7:0]  res4;
    wire  [4:0]  respV;
    wire  [4:0]  busyV;
    wire  [4:0]  errV;

    int          cyc = 0;
    int          testCount = 0;
    int          failCount = 0;

    typedef struct {
        logic [31:0] r;
        int          t0;
    } exp_t;

    exp_t        sbq [NINST][$];
    logic [31:0] acc [NINST];

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle index: cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    fazyrv_ccx_alu #(.CHUNKSIZE(2), .RES_DLY(1), .SELW(2)) u0 (
        .clk_i(clk), .rst_in(rstN), .ccx_sel_i(sel), .ccx_req_i(reqV[0]),
        .ccx_rs_a_i(aIn[0][1:0]), .ccx_rs_b_i(bIn[0][1:0]),
        .ccx_res_o(res0), .ccx_resp_o(respV[0]), .busy_o(busyV[0]), .err_o(errV[0]));

    fazyrv_ccx_alu #(.CHUNKSIZE(1), .RES_DLY(0), .SELW(2)) u1 (
        .clk_i(clk), .rst_in(rstN), .ccx_sel_i(sel), .ccx_req_i(reqV[1]),
        .ccx_rs_a_i(aIn[1][0:0]), .ccx_rs_b_i(bIn[1][0:0]),
        .ccx_res_o(res1), .ccx_resp_o(respV[1]), .busy_o(busyV[1]), .err_o(errV[1]));

    fazyrv_ccx_alu #(.CHUNKSIZE(4), .RES_DLY(15), .SELW(2)) u2 (
        .clk_i(clk), .rst_in(rstN), .ccx_sel_i(sel), .ccx_req_i(reqV[2]),
        .ccx_rs_a_i(aIn[2][3:0]), .ccx_rs_b_i(bIn[2][3:0]),
        .ccx_res_o(res2), .ccx_resp_o(respV[2]), .busy_o(busyV[2]), .err_o(errV[2]));

    fazyrv_ccx_alu #(.CHUNKSIZE(8), .RES_DLY(0), .SELW(2)) u3 (
        .clk_i(clk), .rst_in(rstN), .ccx_sel_i(sel), .ccx_req_i(reqV[3]),
        .ccx_rs_a_i(aIn[3]), .ccx_rs_b_i(bIn[3]),
        .ccx_res_o(res3), .ccx_resp_o(respV[3]), .busy_o(busyV[3]), .err_o(errV[3]));

    fazyrv_ccx_alu #(.CHUNKSIZE(8), .RES_DLY(15), .SELW(2)) u4 (
        .clk_i(clk), .rst_in(rstN), .ccx_sel_i(sel), .ccx_req_i(reqV[4]),
        .ccx_rs_a_i(aIn[4]), .ccx_rs_b_i(bIn[4]),
        .ccx_res_o(res4), .ccx_resp_o(respV[4]), .busy_o(busyV[4]), .err_o(errV[4]));

    function automatic int csOf(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int dlyOf(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            2:       return 15;
            3:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [31:0] resOf(input int i);
        case (i)
            0:       return {30'b0, res0};
            1:       return {31'b0, res1};
            2:       return {28'b0, res2};
            3:       return {24'b0, res3};
            default: return {24'b0, res4};
        endcase
    endfunction

    function automatic logic [31:0] refOp(input logic [1:0] s, input logic [31:0] a,
                                          input logic [31:0] b);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a ^ b;
            2'd2:    return a + b;
            default: return (a < b) ? a : b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one request on every instance in mask, chunking a/b per instance,
    // and record the expected result with its request cycle.
    task automatic applyStimulus(input logic [4:0] mask, input logic [1:0] s,
                                 input logic [31:0] a, input logic [31:0] b);
        int maxN;
        int n;
        logic [31:0] m;
        maxN = 0;
        for (int i = 0; i < NINST; i++) begin
            if (mask[i]) begin
                n = 32 / csOf(i);
                if (n > maxN) maxN = n;
                sbq[i].push_back('{r: refOp(s, a, b), t0: cyc});
            end
        end
        sel = s;
        for (int k = 0; k < maxN; k++) begin
            reqV = (k == 0) ? mask : 5'b0;
            for (int i = 0; i < NINST; i++) begin
                m = (32'h1 << csOf(i)) - 32'h1;
                if (mask[i] && (k < 32 / csOf(i))) begin
                    aIn[i] = 8'((a >> (k * csOf(i))) & m);
                    bIn[i] = 8'((b >> (k * csOf(i))) & m);
                end else begin
                    aIn[i] = 8'h0;
                    bIn[i] = 8'h0;
                end
            end
            waitCycle();
        end
        reqV = 5'b0;
        for (int i = 0; i < NINST; i++) begin
            aIn[i] = 8'h0;
            bIn[i] = 8'h0;
        end
    endtask

    // Wait, with a cycle budget, until every expected result has been seen.
    task automatic waitDone();
        int pending;
        int guard;
        guard = 0;
        pending = 1;
        while (pending != 0 && guard < 300) begin
            pending = 0;
            for (int i = 0; i < NINST; i++) pending += sbq[i].size();
            if (pending != 0) begin
                waitCycle();
                guard++;
            end
        end
        checkOutput("drain pending results", 32'(pending), 32'd0);
    endtask

    // Monitor: inside each expected emit window, gather result chunks and check
    // resp only on the final chunk; outside it, res and resp must stay low.
    always @(negedge clk) begin
        int n;
        int dl;
        int first;
        int last;
        logic [31:0] rv;
        for (int i = 0; i < NINST; i++) begin
            n  = 32 / csOf(i);
            dl = dlyOf(i);
            rv = resOf(i);
            if (sbq[i].size() > 0 &&
                cyc >= sbq[i][0].t0 + n + dl &&
                cyc <= sbq[i][0].t0 + 2 * n + dl - 1) begin
                first = sbq[i][0].t0 + n + dl;
                last  = first + n - 1;
                acc[i] = acc[i] | (rv << ((cyc - first) * csOf(i)));
                if (cyc == last) begin
                    checkOutput($sformatf("u%0d resp on last chunk", i), 32'(respV[i]), 32'd1);
                    checkOutput($sformatf("u%0d reassembled result", i), acc[i], sbq[i][0].r);
                    void'(sbq[i].pop_front());
                    acc[i] = 32'h0;
                end else begin
                    checkOutput($sformatf("u%0d resp early", i), 32'(respV[i]), 32'd0);
                end
            end else begin
                checkOutput($sformatf("u%0d res outside emit", i), rv, 32'd0);
                checkOutput($sformatf("u%0d resp outside emit", i), 32'(respV[i]), 32'd0);
            end
        end
    end

    // Directed sequence of operations, error cases and resets.
    initial begin
        int tb0;
        rstN = 1'b0;
        sel  = 2'd0;
        reqV = 5'b0;
        for (int i = 0; i < NINST; i++) begin
            aIn[i] = 8'h0;
            bIn[i] = 8'h0;
            acc[i] = 32'h0;
        end

        #12;
        checkOutput("reset busy", 32'(busyV), 32'd0);
        checkOutput("reset err", 32'(errV), 32'd0);
        checkOutput("reset resp", 32'(respV), 32'd0);
        for (int i = 0; i < NINST; i++)
            checkOutput($sformatf("u%0d reset res", i), resOf(i), 32'd0);
        rstN = 1'b1;
        waitCycle();

        applyStimulus(5'h1F, 2'd0, 32'hF0F0_1234, 32'hFF00_FF0F);
        waitDone();
        applyStimulus(5'h1F, 2'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        waitDone();
        applyStimulus(5'h1F, 2'd3, 32'h8000_0000, 32'h7FFF_FFFF);
        waitDone();
        applyStimulus(5'h1F, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        waitDone();
        applyStimulus(5'h1F, 2'd3, 32'h0000_0005, 32'hFFFF_FFF0);
        waitDone();
        for (int r = 0; r < 3; r++) begin
            applyStimulus(5'h1F, 2'($urandom_range(0, 3)), $urandom, $urandom);
            waitDone();
        end

        // u2 sits in WAIT from t0+8 to t0+22; a request at t0+12 must be dropped.
        applyStimulus(5'b00100, 2'd2, 32'h1234_5678, 32'h1111_1111);
        repeat (4) waitCycle();
        checkOutput("u2 busy during wait", 32'(busyV[2]), 32'd1);
        sel     = 2'd0;
        reqV[2] = 1'b1;
        aIn[2]  = 8'h0F;
        bIn[2]  = 8'h0F;
        waitCycle();
        reqV[2] = 1'b0;
        aIn[2]  = 8'h0;
        bIn[2]  = 8'h0;
        waitDone();
        checkOutput("u2 err after req in wait", 32'(errV[2]), 32'd1);

        // u0 resp lands at t0+32; a new request at t0+33 is accepted cleanly.
        tb0 = cyc;
        applyStimulus(5'b00001, 2'd0, 32'hA5A5_A5A5, 32'h0FF0_0FF0);
        while (cyc < tb0 + 33) waitCycle();
        checkOutput("u0 idle after resp", 32'(busyV[0]), 32'd0);
        applyStimulus(5'b00001, 2'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        waitDone();
        checkOutput("err flags after back-to-back", 32'(errV), 32'b00100);

        // Reset in the middle of a u0 collect phase.
        sel     = 2'd1;
        reqV[0] = 1'b1;
        aIn[0]  = 8'h3;
        bIn[0]  = 8'h1;
        waitCycle();
        reqV[0] = 1'b0;
        repeat (3) waitCycle();
        checkOutput("u0 busy mid collect", 32'(busyV[0]), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(busyV), 32'd0);
        checkOutput("async reset err", 32'(errV), 32'd0);
        checkOutput("async reset resp", 32'(respV), 32'd0);
        checkOutput("async reset u0 res", resOf(0), 32'd0);
        aIn[0] = 8'h0;
        bIn[0] = 8'h0;
        #2;
        rstN = 1'b1;
        waitCycle();
        applyStimulus(5'h1F, 2'd2, 32'h0123_4567, 32'h89AB_CDEF);
        waitDone();
        checkOutput("err clear after reset", 32'(errV), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
